// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the ROM message sequencer.
package rom_seq_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int NUM_REQ    = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the requester that wins
// a tie; it moves past whoever was granted, so back-to-back ties alternate.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic ptr;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

  // One-hot grant: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the other requester after every grant actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (en && (grant != 2'b00))
      ptr <= grant[0];
  end

endmodule

// File: rtl/rom_msg_sequencer.sv
// Shares one synchronous message ROM between two requesters and streams the
// selected NUL-terminated string to a valid/ready transmitter, one byte per
// FETCH -> CHECK -> SEND round trip.
module rom_msg_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_LEN = 64
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ADDR_W-1:0]  i_base0,
  input  logic [ADDR_W-1:0]  i_base1,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [NUM_REQ-1:0] o_done,
  output logic               o_err,
  output logic               o_busy,
  output logic               o_rom_en,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [7:0]         i_rom_data,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_ready
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr;
  logic [CNT_W-1:0]     cnt;
  logic                 err_flag;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 at_limit;
  logic                 nul_byte;

  rr_arbiter2 u_arb (
    .clk   (i_clock),
    .rst   (i_reset),
    .req   (i_req),
    .en    (state == IDLE),
    .grant (arb_grant)
  );

  assign at_limit   = (cnt == CNT_MAX);
  assign nul_byte   = (i_rom_data == 8'd0);

  // Decoded outputs so an asynchronous reset clears them with the state.
  assign o_busy     = (state != IDLE);
  assign o_rom_en   = (state == FETCH);
  assign o_rom_addr = addr;
  assign o_tx_valid = (state == SEND);

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; request drops mid-message are deliberately ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req != '0) state_nxt = FETCH;
      FETCH:   state_nxt = CHECK;
      CHECK:   state_nxt = (nul_byte || at_limit) ? DONE : SEND;
      SEND:    if (i_tx_ready) state_nxt = FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, count, captured byte and registered grant/done/err outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      addr      <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      o_grant   <= '0;
      o_done    <= '0;
      o_err     <= 1'b0;
      o_tx_data <= 8'd0;
    end else begin
      o_done <= '0;
      o_err  <= 1'b0;
      case (state)
        IDLE: if (i_req != '0) begin
          o_grant  <= arb_grant;
          addr     <= arb_grant[1] ? i_base1 : i_base0;
          cnt      <= '0;
          err_flag <= 1'b0;
        end
        CHECK: if (!nul_byte) begin
          if (at_limit) err_flag  <= 1'b1;
          else          o_tx_data <= i_rom_data;
        end
        // Count only advances after a send, which needs count < MAX_LEN.
        SEND: if (i_tx_ready) begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt + CNT_W'(1);
        end
        DONE: begin
          o_done  <= o_grant;
          o_err   <= err_flag;
          o_grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_msg_sequencer.sv
// Directed bench: two sequencers (MAX_LEN 64 and 4) share one ROM image.
module tb_rom_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req4;
  logic [6:0] base0, base1, base4;
  logic       ready;

  logic [1:0] grant, done, grant4, done4;
  logic       err, busy, rom_en, tx_valid;
  logic       err4, busy4, rom_en4, tx_valid4;
  logic [6:0] rom_addr, rom_addr4;
  logic [7:0] tx_data, tx_data4, rom_q, rom_q4;

  logic [7:0] rom [0:127];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0;

  logic [7:0] bytes[$], b4[$];
  int         bcyc[$], dcyc[$];
  logic [1:0] dones[$], grants[$], d4[$];
  logic       errs[$], e4[$];
  logic [6:0] addrs[$];
  logic       prev_v, prev_r;
  logic [7:0] prev_d;
  logic [1:0] prev_g;

  always #5 clk = ~clk;

  rom_msg_sequencer #(.ADDR_W(7), .MAX_LEN(64)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_base0(base0), .i_base1(base1),
    .o_grant(grant), .o_done(done), .o_err(err), .o_busy(busy),
    .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_q),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(ready)
  );

  rom_msg_sequencer #(.ADDR_W(7), .MAX_LEN(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_req(req4), .i_base0(base4), .i_base1(base4),
    .o_grant(grant4), .o_done(done4), .o_err(err4), .o_busy(busy4),
    .o_rom_en(rom_en4), .o_rom_addr(rom_addr4), .i_rom_data(rom_q4),
    .o_tx_valid(tx_valid4), .o_tx_data(tx_data4), .i_tx_ready(1'b1)
  );

  // Synchronous ROM model: data valid the cycle after enable.
  always @(posedge clk) begin
    if (rom_en)  rom_q  <= rom[rom_addr];
    if (rom_en4) rom_q4 <= rom[rom_addr4];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] q[$], input string s);
    chk({tag, " len"}, q.size(), s.len());
    for (int i = 0; i < s.len(); i++)
      chk({tag, " byte"}, (i < q.size()) ? q[i] : 8'hxx, s[i]);
  endtask

  task automatic clr();
    bytes.delete(); bcyc.delete(); dcyc.delete(); dones.delete();
    grants.delete(); errs.delete(); addrs.delete(); b4.delete(); d4.delete(); e4.delete();
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done != 2'b00) break;
    end
    chk({tag, " done seen"}, (done != 2'b00) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor on the falling edge: log handshakes, pulses, reads, new grants,
  // and require a stalled byte to stay put.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_v && !prev_r) begin
        chk("hold valid", tx_valid, 1);
        chk("hold data", tx_data, prev_d);
      end
      if (tx_valid && ready) begin bytes.push_back(tx_data); bcyc.push_back(cyc); end
      if (done != 2'b00) begin dones.push_back(done); dcyc.push_back(cyc); errs.push_back(err); end
      if (rom_en) addrs.push_back(rom_addr);
      if (grant != 2'b00 && grant != prev_g) grants.push_back(grant);
      if (tx_valid4) b4.push_back(tx_data4);
      if (done4 != 2'b00) begin d4.push_back(done4); e4.push_back(err4); end
      prev_v = tx_valid; prev_r = ready; prev_d = tx_data; prev_g = grant;
    end else begin
      prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'd0; prev_g = 2'b00;
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    rom[8]  = "H"; rom[9]  = "i";
    rom[16] = "Y"; rom[17] = "o";
    for (int i = 0; i < 7; i++) rom[24+i] = 8'h41 + 8'(i);   // "ABCDEFG"
    rom[32] = "H"; rom[33] = "e"; rom[34] = "l"; rom[35] = "l"; rom[36] = "o";
    rom[126] = "A"; rom[127] = "B";

    rst = 1'b1; req = 2'b00; req4 = 2'b00; ready = 1'b1;
    base0 = 7'd0; base1 = 7'd0; base4 = 7'd0;
    prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'd0; prev_g = 2'b00;

    // Reset state
    #3;
    chk("rst grant", grant, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst busy", busy, 0);
    chk("rst rom_en", rom_en, 0);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst tx_valid", tx_valid, 0);
    chk("rst tx_data", tx_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Hello from requester 0, request dropped after grant
    #1 clr(); base0 = 7'd32; req = 2'b01; t0 = cyc;
    @(posedge clk); #1;
    chk("t1 grant", grant, 2'b01);
    chk("t1 busy", busy, 1);
    chk("t1 rom_en", rom_en, 1);
    chk("t1 rom_addr", rom_addr, 32);
    req = 2'b00;
    wait_done(60, "t1");
    repeat (2) @(posedge clk);
    chk_q("t1 hello", bytes, "Hello");
    for (int k = 0; k < 5; k++) chk("t1 byte cyc", (k < bcyc.size()) ? bcyc[k] : -1, t0 + 3*k + 3);
    chk("t1 done count", dones.size(), 1);
    chk("t1 done val", (dones.size() > 0) ? dones[0] : 2'bxx, 2'b01);
    chk("t1 done cyc", (dcyc.size() > 0) ? dcyc[0] : -1, t0 + 19);
    chk("t1 err", (errs.size() > 0) ? errs[0] : 1'bx, 0);
    chk("t1 idle busy", busy, 0);

    // Both held: grants alternate 01,10,01 from a fresh pointer
    do_reset();
    #1 clr(); base0 = 7'd8; base1 = 7'd16; req = 2'b11;
    for (int m = 0; m < 3; m++) begin
      wait_done(40, "t2");
      chk("t2 done owner", done, (m == 1) ? 2'b10 : 2'b01);
    end
    req = 2'b00;
    repeat (4) @(posedge clk);
    chk("t2 grant count", grants.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2 grant seq", (i < grants.size()) ? grants[i] : 2'bxx, (i == 1) ? 2'b10 : 2'b01);
      chk("t2 done seq", (i < dones.size()) ? dones[i] : 2'bxx, (i == 1) ? 2'b10 : 2'b01);
    end
    chk_q("t2 bytes", bytes, "HiYoHi");

    // Empty string: done after E+3, nothing sent
    #1 clr(); base0 = 7'd20; req = 2'b01; t0 = cyc;
    @(posedge clk); #1 req = 2'b00;
    wait_done(20, "t7");
    repeat (2) @(posedge clk);
    chk("t7 bytes", bytes.size(), 0);
    chk("t7 done cyc", (dcyc.size() > 0) ? dcyc[0] : -1, t0 + 4);
    chk("t7 done val", (dones.size() > 0) ? dones[0] : 2'bxx, 2'b01);

    // Backpressure on byte 2 for several cycles
    #1 clr(); base0 = 7'd32; req = 2'b01;
    @(posedge clk); #1 req = 2'b00;
    for (int k = 0; k < 20 && bytes.size() < 1; k++) begin @(posedge clk); #1; end
    ready = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("t3 stalled byte", tx_data, 8'h65);
    chk("t3 stalled valid", tx_valid, 1);
    ready = 1'b1;
    wait_done(60, "t3");
    repeat (2) @(posedge clk);
    chk_q("t3 hello", bytes, "Hello");
    chk("t3 done count", dones.size(), 1);

    // Wrap across top of address space
    #1 clr(); base1 = 7'd126; req = 2'b10;
    @(posedge clk); #1 req = 2'b00;
    wait_done(30, "t5");
    repeat (2) @(posedge clk);
    chk_q("t5 bytes", bytes, "AB");
    chk("t5 addr count", addrs.size(), 3);
    chk("t5 addr0", (addrs.size() > 0) ? addrs[0] : 7'hxx, 126);
    chk("t5 addr1", (addrs.size() > 1) ? addrs[1] : 7'hxx, 127);
    chk("t5 addr2", (addrs.size() > 2) ? addrs[2] : 7'hxx, 0);
    chk("t5 done val", (dones.size() > 0) ? dones[0] : 2'bxx, 2'b10);

    // MAX_LEN=4 with no NUL in range: 4 bytes then done+err together
    #1 clr(); base4 = 7'd24; req4 = 2'b01;
    @(posedge clk); #1 req4 = 2'b00;
    for (int k = 0; k < 40 && d4.size() < 1; k++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);
    chk_q("t4 bytes", b4, "ABCD");
    chk("t4 done count", d4.size(), 1);
    chk("t4 done val", (d4.size() > 0) ? d4[0] : 2'bxx, 2'b01);
    chk("t4 err", (e4.size() > 0) ? e4[0] : 1'bx, 1);

    // Reset during SEND, then a clean restart
    #1 clr(); ready = 1'b0; base0 = 7'd32; req = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (tx_valid) break;
    end
    chk("t6 in send", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6 async valid", tx_valid, 0);
    chk("t6 async grant", grant, 0);
    chk("t6 async busy", busy, 0);
    chk("t6 async data", tx_data, 0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    chk("t6 no done", done, 0);
    #1 rst = 1'b0; ready = 1'b1;
    chk("t6 no done logged", dones.size(), 0);
    @(posedge clk);
    #1 clr(); base0 = 7'd8; req = 2'b01;
    @(posedge clk); #1 req = 2'b00;
    wait_done(30, "t6");
    repeat (2) @(posedge clk);
    chk_q("t6 restart", bytes, "Hi");
    chk("t6 restart addr", (addrs.size() > 0) ? addrs[0] : 7'hxx, 8);
    chk("t6 restart done", (dones.size() > 0) ? dones[0] : 2'bxx, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
